// File: rtl/prime_gen_if.sv
// Stream and control bundle for prime_gen: scan request, bounds, prime stream and status.
// The requester uses the master modport and prime_gen uses the slave modport.
interface prime_gen_if;
    logic       start;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] prime_out;
    logic       prime_valid;
    logic       prime_ready;
    logic       busy;
    logic       done;
    logic [5:0] count;

    modport master (
        output start, lo, hi, prime_ready,
        input  prime_out, prime_valid, busy, done, count
    );

    modport slave (
        input  start, lo, hi, prime_ready,
        output prime_out, prime_valid, busy, done, count
    );
endinterface

// File: rtl/prime_gen.sv
// Streams every prime in [lo, hi] in ascending order, found by trial division using repeated subtraction.
// Define PRIME_GEN_SQRT_EN to end the divisor loop once d*d > candidate instead of at d = candidate.
module prime_gen (
    input  logic        clk,
    input  logic        rst,
    prime_gen_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, EMIT, FIN} state_t;

    state_t     state_q, state_d;
    logic [8:0] cand_q, cand_d;
    logic [7:0] hi_q, hi_d;
    logic [8:0] div_q, div_d;
    logic [8:0] rem_q, rem_d;
    logic [7:0] prime_q, prime_d;
    logic [5:0] count_q, count_d;
    logic       div_exhausted;

`ifdef PRIME_GEN_SQRT_EN
    logic [15:0] div_sq;
    assign div_sq        = {7'd0, div_q} * {7'd0, div_q};
    assign div_exhausted = div_sq > {7'd0, cand_q};
`else
    assign div_exhausted = (div_q == cand_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            hi_q    <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            prime_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            hi_q    <= hi_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            prime_q <= prime_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        hi_d    = hi_q;
        div_d   = div_q;
        rem_d   = rem_q;
        prime_d = prime_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cand_d  = {1'b0, bus.lo};
                    hi_d    = bus.hi;
                    count_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // The 9-bit candidate lets 256 exceed hi = 255 instead of wrapping to 0.
                if (cand_q > {1'b0, hi_q}) begin
                    state_d = FIN;
                end else if (cand_q < 9'd2) begin
                    cand_d = cand_q + 9'd1;
                end else begin
                    div_d   = 9'd2;
                    rem_d   = cand_q;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (div_exhausted) begin
                    prime_d = cand_q[7:0];
                    state_d = EMIT;
                end else if (rem_q == 9'd0) begin
                    cand_d  = cand_q + 9'd1;
                    state_d = LOAD;
                end else if (rem_q < div_q) begin
                    div_d = div_q + 9'd1;
                    rem_d = cand_q;
                end else begin
                    rem_d = rem_q - div_q;
                end
            end
            EMIT: begin
                if (bus.prime_ready) begin
                    count_d = count_q + 6'd1;
                    cand_d  = cand_q + 9'd1;
                    state_d = LOAD;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.prime_out   = prime_q;
    assign bus.prime_valid = (state_q == EMIT);
    assign bus.done        = (state_q == FIN);
    assign bus.busy        = (state_q != IDLE);
    assign bus.count       = count_q;

endmodule

// File: tb/tb_prime_gen.sv
// Self-checking bench for prime_gen: table-driven scans plus hand-written reset-abort sequence.
// Expected streams come from hand-computed table fields and a modulo-based primality model.
module tb_prime_gen;

    typedef struct {
        int lo;
        int hi;
        int stall;
        bit poke;
        int expCount;
        int expFirst;
        int expLast;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   got[$];
    int   expStream[$];
    vec_t vecs[9];

    prime_gen_if bus();

    prime_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic bit isPrime(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k < n; k++)
            if (n % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic applyStimulus(input int loV, input int hiV);
        @(negedge clk);
        bus.start = 1'b1;
        bus.lo    = loV[7:0];
        bus.hi    = hiV[7:0];
    endtask

    // Watches one scan after its start was driven; records accepted primes into got.
    task automatic finishScan(input vec_t v, input string tag);
        int  stallLeft;
        int  held;
        bit  stableBad;
        bit  overlap;
        bit  finished;
        int  n;
        stallLeft = v.stall;
        held      = -1;
        stableBad = 1'b0;
        overlap   = 1'b0;
        finished  = 1'b0;
        got.delete();
        expStream.delete();
        for (int p = v.lo; p <= v.hi; p++)
            if (isPrime(p)) expStream.push_back(p);

        for (int cyc = 0; cyc < 70000 && !finished; cyc++) begin
            @(negedge clk);
            if (v.poke && cyc == 3) begin
                bus.start = 1'b1;
                bus.lo    = 8'd200;
                bus.hi    = 8'd210;
            end else begin
                bus.start = 1'b0;
            end
            if (cyc == 0) begin
                checkOutput({tag, "_busyAfterStart"}, int'(bus.busy), 1);
                checkOutput({tag, "_countCleared"}, int'(bus.count), 0);
            end
            if (bus.prime_valid && bus.done) overlap = 1'b1;
            if (bus.prime_valid) begin
                if (stallLeft > 0) begin
                    if (stallLeft == v.stall) held = int'(bus.prime_out);
                    else if (int'(bus.prime_out) != held) stableBad = 1'b1;
                    bus.prime_ready = 1'b0;
                    stallLeft--;
                end else begin
                    if (v.stall > 0 && got.size() == 0 && int'(bus.prime_out) != held)
                        stableBad = 1'b1;
                    bus.prime_ready = 1'b1;
                    got.push_back(int'(bus.prime_out));
                end
            end else begin
                bus.prime_ready = 1'b1;
            end
            if (bus.done) finished = 1'b1;
        end
        checkOutput({tag, "_doneSeen"}, int'(finished), 1);
        checkOutput({tag, "_validDoneOverlap"}, int'(overlap), 0);

        @(negedge clk);
        checkOutput({tag, "_donePulseOnce"}, int'(bus.done), 0);
        checkOutput({tag, "_busyCleared"}, int'(bus.busy), 0);
        checkOutput({tag, "_count"}, int'(bus.count), v.expCount);
        checkOutput({tag, "_numPrimes"}, got.size(), v.expCount);
        n = (got.size() < expStream.size()) ? got.size() : expStream.size();
        for (int i = 0; i < n; i++)
            checkOutput({tag, "_prime"}, got[i], expStream[i]);
        if (got.size() > 0) begin
            checkOutput({tag, "_firstPrime"}, got[0], v.expFirst);
            checkOutput({tag, "_lastPrime"}, got[got.size()-1], v.expLast);
        end
        if (v.stall > 0) begin
            checkOutput({tag, "_stallStable"}, int'(stableBad), 0);
            checkOutput({tag, "_stallHeld"}, held, v.expFirst);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_primeOut"}, int'(bus.prime_out), 0);
        checkOutput({tag, "_primeValid"}, int'(bus.prime_valid), 0);
        checkOutput({tag, "_busy"}, int'(bus.busy), 0);
        checkOutput({tag, "_done"}, int'(bus.done), 0);
        checkOutput({tag, "_count"}, int'(bus.count), 0);
    endtask

    initial begin
        vec_t rv;
        bit   found;
        bit   leaked;
        checks = 0;
        errors = 0;

        vecs[0] = '{lo:0,   hi:20,  stall:0, poke:1'b0, expCount:8,  expFirst:2,   expLast:19};
        vecs[1] = '{lo:250, hi:255, stall:0, poke:1'b0, expCount:1,  expFirst:251, expLast:251};
        vecs[2] = '{lo:24,  hi:28,  stall:0, poke:1'b0, expCount:0,  expFirst:0,   expLast:0};
        vecs[3] = '{lo:30,  hi:10,  stall:0, poke:1'b0, expCount:0,  expFirst:0,   expLast:0};
        vecs[4] = '{lo:0,   hi:255, stall:5, poke:1'b0, expCount:54, expFirst:2,   expLast:251};
        vecs[5] = '{lo:0,   hi:20,  stall:0, poke:1'b1, expCount:8,  expFirst:2,   expLast:19};
        vecs[6] = '{lo:2,   hi:2,   stall:0, poke:1'b0, expCount:1,  expFirst:2,   expLast:2};
        vecs[7] = '{lo:0,   hi:1,   stall:0, poke:1'b0, expCount:0,  expFirst:0,   expLast:0};
        vecs[8] = '{lo:241, hi:241, stall:0, poke:1'b0, expCount:1,  expFirst:241, expLast:241};

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.lo          = 8'd0;
        bus.hi          = 8'd0;
        bus.prime_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkResetState("powerOnReset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            $display("[TB] scan %0d lo=%0d hi=%0d", i, vecs[i].lo, vecs[i].hi);
            applyStimulus(vecs[i].lo, vecs[i].hi);
            finishScan(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while stalling on prime 7, then restart on the first cycle rst is low.
        applyStimulus(0, 20);
        found = 1'b0;
        for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.prime_valid && bus.prime_out == 8'd7) begin
                bus.prime_ready = 1'b0;
                found = 1'b1;
            end else begin
                bus.prime_ready = 1'b1;
            end
        end
        checkOutput("abort_reachedSeven", int'(found), 1);
        @(negedge clk);
        checkOutput("abort_stallValid", int'(bus.prime_valid), 1);
        checkOutput("abort_stallPrime", int'(bus.prime_out), 7);
        rst = 1'b1;
        @(negedge clk);
        checkResetState("abortReset");
        rst = 1'b0;
        bus.prime_ready = 1'b1;
        leaked = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.prime_valid || bus.done || bus.busy) leaked = 1'b1;
        end
        checkOutput("abort_noLeak", int'(leaked), 0);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b1;
        bus.lo    = 8'd5;
        bus.hi    = 8'd7;
        rv = '{lo:5, hi:7, stall:0, poke:1'b0, expCount:2, expFirst:5, expLast:7};
        finishScan(rv, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prime_gen.md
PRIME_GEN -- requirements
Module: prime_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-005 lo  input  8  inclusive lower bound of the scan; captured on accepted start.
REQ-006 hi  input  8  inclusive upper bound of the scan; captured on accepted start.
REQ-007 prime_out  output  8  current prime being offered.
REQ-008 prime_valid  output  1  prime_out holds a valid prime.
REQ-009 prime_ready  input  1  consumer accepts prime_out when high with prime_valid.
REQ-010 busy  output  1  high from accepted start until done.
REQ-011 done  output  1  one-cycle pulse at the end of a scan.
REQ-012 count  output  6  number of primes accepted in the current or last scan.

Function
REQ-013 The block SHALL emit, in ascending order, every prime p with lo <= p <= hi, each exactly once, on a valid/ready stream.
REQ-014 FSM states SHALL be IDLE, LOAD, DIV, EMIT and FIN.
- IDLE -> LOAD on start.
- LOAD -> DIV for a candidate >= 2.
- LOAD -> next candidate for a candidate of 0 or 1.
- LOAD -> FIN when the candidate exceeds the captured hi.
REQ-015 The candidate register SHALL be 9 bits wide so that incrementing past 255 never wraps; a scan with hi = 255 SHALL terminate.
REQ-016 DIV SHALL test divisors d = 2, 3, ... by repeated subtraction, one subtraction per cycle; no divide or modulo operator SHALL be used.
REQ-017 A zero remainder for any tested d SHALL mark the candidate composite, advance to the next candidate, and return to LOAD.
REQ-018 Exhausting the divisors without a zero remainder SHALL mark the candidate prime and move to EMIT.
REQ-019 In EMIT, prime_valid SHALL be high.
- prime_out SHALL stay stable while prime_valid = 1 and prime_ready = 0.
- The transfer completes in the cycle where both prime_valid and prime_ready are high.
- count SHALL increment by 1 on that cycle, and the FSM returns to LOAD with the next candidate.
REQ-020 FIN SHALL assert done for exactly one cycle, then return to IDLE with busy = 0.
REQ-021 If the captured lo > hi, the block SHALL go LOAD -> FIN, emit nothing, and leave count = 0.
REQ-022 start SHALL be ignored while busy = 1.
REQ-023 count SHALL clear to 0 on an accepted start and hold its final value until the next accepted start.
REQ-024 prime_valid SHALL never be high outside EMIT; done and prime_valid SHALL never be high in the same cycle.

Reset
REQ-025 With rst high at a clock edge, the FSM SHALL go to IDLE.
- Reset values: prime_out = 0, prime_valid = 0, busy = 0, done = 0, count = 0.
REQ-026 Reset asserted mid-scan, including during an EMIT stall, SHALL abort the scan with no further prime or done issued.
REQ-027 The first accepted start after reset release SHALL be honoured on the first cycle rst is low.

Configuration
REQ-028 Macro PRIME_GEN_SQRT_EN defined:
- The divisor loop SHALL stop once d*d > candidate.
- The product d*d SHALL be computed at 16-bit width.
REQ-029 Macro PRIME_GEN_SQRT_EN undefined: the divisor loop SHALL stop when d = candidate.
REQ-030 The prime stream and count SHALL be identical with and without the macro; only latency differs.

Verification
REQ-031 lo=0, hi=20, prime_ready held 1 -> stream 2,3,5,7,11,13,17,19; done pulses once; count=8.
REQ-032 lo=250, hi=255 -> single prime 251; done pulses once; count=1; no wrap to candidate 0.
REQ-033 lo=24, hi=28 -> no prime_valid; done pulses once; count=0. Separately, lo=30, hi=10 -> no prime_valid; done pulses once; count=0.
REQ-034 lo=0, hi=255 with prime_ready low for 5 cycles on the first prime -> prime_out=2 stable throughout the stall; 54 primes total; last prime 251; count=54.
REQ-035 rst pulsed while offering prime 7 (lo=0, hi=20) -> all outputs at reset values next cycle; a new start with lo=5, hi=7 -> stream 5,7; count=2.
REQ-036 Every scenario above SHALL be run with and without PRIME_GEN_SQRT_EN, and the prime streams SHALL be identical.
